// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO stack with peek, replace, occupancy count and sticky error flags
// The pointer is the occupancy count itself; slot count-1 is the top of stack.
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             pop_valid_q, pop_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] top_w;
  logic             full_w, empty_w;

  assign full_w   = (count_q == FULL_CNT);
  assign empty_w  = (count_q == '0);
  assign top_addr = AW'(count_q - 1'b1);
  assign top_w    = empty_w ? '0 : mem[top_addr];

  always_comb begin
    count_d     = count_q;
    data_out_d  = data_out_q;
    pop_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_addr     = AW'(count_q);

    if (clear) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (full_w) begin
            overflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        2'b01: begin
          if (empty_w) begin
            underflow_d = 1'b1;
          end else begin
            data_out_d  = top_w;
            pop_valid_d = 1'b1;
            count_d     = count_q - 1'b1;
          end
        end
        2'b11: begin
          // Replace overwrites the top in place; on an empty stack only the push half succeeds.
          if (empty_w) begin
            wr_en       = 1'b1;
            count_d     = count_q + 1'b1;
            underflow_d = 1'b1;
          end else begin
            data_out_d  = top_w;
            pop_valid_d = 1'b1;
            wr_en       = 1'b1;
            wr_addr     = top_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      data_out_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign pop_valid = pop_valid_q;
  assign top       = top_w;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - randomized and directed check of lifo_stack against a queue-based model
module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0, pop = 1'b0, clear = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out, top;
  logic             pop_valid, full, empty, overflow, underflow;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference state: contents as a queue (back = top) plus the registered outputs.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout;
  bit               m_pv, m_ovf, m_unf;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear),
    .data_in(data_in), .data_out(data_out), .pop_valid(pop_valid),
    .top(top), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_top();
    return (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_dout = '0;
    m_pv = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_edge(input bit pu, input bit po, input bit cl, input logic [WIDTH-1:0] d);
    m_pv = 0;
    if (cl) begin
      m_q.delete();
      m_ovf = 0; m_unf = 0;
    end else if (pu && po) begin
      if (m_q.size() == 0) begin
        m_q.push_back(d);
        m_unf = 1;
      end else begin
        m_dout = m_q[m_q.size()-1];
        m_pv = 1;
        m_q[m_q.size()-1] = d;
      end
    end else if (pu) begin
      if (m_q.size() == DEPTH) m_ovf = 1;
      else m_q.push_back(d);
    end else if (po) begin
      if (m_q.size() == 0) m_unf = 1;
      else begin
        m_dout = m_q.pop_back();
        m_pv = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("count",     32'(count),     32'(m_q.size()));
      check("full",      32'(full),      32'(m_q.size() == DEPTH));
      check("empty",     32'(empty),     32'(m_q.size() == 0));
      check("top",       32'(top),       32'(m_top()));
      check("data_out",  32'(data_out),  32'(m_dout));
      check("pop_valid", 32'(pop_valid), 32'(m_pv));
      check("overflow",  32'(overflow),  32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
    end
  end

  // Drive one edge worth of inputs, advance the model at the edge, return at the next negedge.
  task automatic step(input bit pu, input bit po, input bit cl, input logic [WIDTH-1:0] d);
    push = pu; pop = po; clear = cl; data_in = d;
    @(posedge clk);
    model_edge(pu, po, cl, d);
    @(negedge clk);
    push = 0; pop = 0; clear = 0;
  endtask

  // Pulse rst between edges and confirm the flops clear before any clock edge.
  task automatic async_reset(input bit lit);
    push = 0; pop = 0; clear = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    if (lit) begin
      check("arst_count", 32'(count),     32'd0);
      check("arst_dout",  32'(data_out),  32'd0);
      check("arst_ovf",   32'(overflow),  32'd0);
      check("arst_unf",   32'(underflow), 32'd0);
      check("arst_empty", 32'(empty),     32'd1);
      check("arst_top",   32'(top),       32'd0);
    end
    #1 rst = 1'b0;
  endtask

  logic [WIDTH-1:0] pattern [4];

  initial begin
    pattern[0] = 8'h11; pattern[1] = 8'h22; pattern[2] = 8'h33; pattern[3] = 8'h44;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_count", 32'(count),     32'd0);
    check("rst_empty", 32'(empty),     32'd1);
    check("rst_full",  32'(full),      32'd0);
    check("rst_top",   32'(top),       32'd0);
    check("rst_dout",  32'(data_out),  32'd0);
    check("rst_pv",    32'(pop_valid), 32'd0);
    chk_on = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, pattern[i]);
      check("fill_count", 32'(count), 32'(i + 1));
    end
    check("fill_top",  32'(top),  32'h44);
    check("fill_full", 32'(full), 32'd1);
    step(1, 0, 0, 8'h55);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'd4);
    check("ovf_top",   32'(top),      32'h44);

    for (int i = 3; i >= 0; i--) begin
      step(0, 1, 0, 8'h00);
      check("pop_dout", 32'(data_out),  32'(pattern[i]));
      check("pop_pv",   32'(pop_valid), 32'd1);
    end
    check("pop_empty", 32'(empty), 32'd1);
    step(0, 1, 0, 8'h00);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_pv",   32'(pop_valid), 32'd0);
    check("unf_dout", 32'(data_out),  32'h11);

    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'hA0);
    step(1, 0, 0, 8'hB0);
    step(1, 1, 0, 8'hC0);
    check("rep_dout",  32'(data_out),  32'hB0);
    check("rep_pv",    32'(pop_valid), 32'd1);
    check("rep_count", 32'(count),     32'd2);
    check("rep_top",   32'(top),       32'hC0);
    step(1, 0, 0, 8'hC1);
    step(1, 0, 0, 8'hC2);
    step(1, 1, 0, 8'hD0);
    check("repf_dout",  32'(data_out), 32'hC2);
    check("repf_ovf",   32'(overflow), 32'd0);
    check("repf_count", 32'(count),    32'd4);
    check("repf_top",   32'(top),      32'hD0);

    step(0, 0, 1, 8'h00);
    step(1, 1, 0, 8'h5A);
    check("epp_count", 32'(count),     32'd1);
    check("epp_top",   32'(top),       32'h5A);
    check("epp_unf",   32'(underflow), 32'd1);
    check("epp_pv",    32'(pop_valid), 32'd0);

    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h60 + 8'(i));
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h70);
    step(1, 0, 0, 8'h71);
    check("pre_clr_flags", 32'({overflow, underflow}), 32'h3);
    step(0, 0, 1, 8'h00);
    check("clr_count", 32'(count),     32'd0);
    check("clr_empty", 32'(empty),     32'd1);
    check("clr_ovf",   32'(overflow),  32'd0);
    check("clr_unf",   32'(underflow), 32'd0);
    check("clr_dout",  32'(data_out),  32'h63);

    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h90 + 8'(i));
    async_reset(1);
    step(1, 0, 0, 8'h77);
    check("post_rst_top", 32'(top), 32'h77);

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        step(($urandom & 1) != 0, ($urandom & 1) != 0, 1, 8'($urandom));
      end else if (r < 3) begin
        async_reset(0);
      end else begin
        step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), 0, 8'($urandom));
      end
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
